edge_max_pool: RTL and testbench

- 2x2, stride-2 max-pooling stage directly downstream of the Sobel edge-magnitude stage.
- Consumes the 12-bit gradient-magnitude stream in raster order.
- Emits one pooled 12-bit pixel per 2x2 tile with a valid/ready handshake.
- Its ready_out drives the Sobel stage's pooling-backpressure input.

---
 rtl/pool_pkg.sv | 27 ++
 rtl/edge_max_pool_if.sv | 22 ++
 rtl/pool_line_buf.sv | 23 ++
 rtl/edge_max_pool.sv | 108 ++++++++++
 tb/tb_edge_max_pool.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared constants and types for the 2x2 stride-2 pooling stage behind the Sobel magnitude.
// POOL_AVG_EN switches the line-buffer width for average pooling.
package pool_pkg;

  localparam int PIX_W          = 12;
  localparam int IMG_WIDTH_DEF  = 62;
  localparam int IMG_HEIGHT_DEF = 62;

  // Phase is {row[0], col[0]} so the enum encoding matches the counter LSBs.
  typedef enum logic [1:0] {
    ROW_EVEN_A = 2'b00,
    ROW_EVEN_B = 2'b01,
    ROW_ODD_A  = 2'b10,
    ROW_ODD_B  = 2'b11
  } phase_t;

  function automatic int lb_depth(input int img_width);
    return (img_width / 2 < 1) ? 1 : img_width / 2;
  endfunction

`ifdef POOL_AVG_EN
  localparam int LB_W = PIX_W + 1;
`else
  localparam int LB_W = PIX_W;
`endif

endpackage

// File: rtl/edge_max_pool_if.sv
// Pixel stream in from the Sobel stage and pooled stream out, with valid/ready on both sides.
interface edge_max_pool_if
  import pool_pkg::*;
();
  logic [PIX_W-1:0] pixel_in;
  logic             valid_in;
  logic             ready_out;
  logic [PIX_W-1:0] pixel_out;
  logic             valid_out;
  logic             last_out;
  logic             ready_in;

  modport slave (
    input  pixel_in, valid_in, ready_in,
    output ready_out, pixel_out, valid_out, last_out
  );

  modport master (
    output pixel_in, valid_in, ready_in,
    input  ready_out, pixel_out, valid_out, last_out
  );
endinterface

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer holding one pooled pair result per tile column; 1-cycle read.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH = 31,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [LB_W-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [LB_W-1:0] rd_data
);
  logic [LB_W-1:0] mem [DEPTH];

  // rd_data holds until the next read, so the ODD_B pixel may arrive any time later.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/edge_max_pool.sv
// 2x2 stride-2 pooling of the gradient-magnitude raster; max by default, average with POOL_AVG_EN.
// One-deep output register; ready_out passes downstream ready through when it drains.
module edge_max_pool
  import pool_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input logic            clk_200mhz,
  input logic            reset_n,
  edge_max_pool_if.slave pif
);
  localparam int CW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DEPTH = lb_depth(IMG_WIDTH);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_END  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(2 * (IMG_WIDTH / 2) - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 * (IMG_HEIGHT / 2) - 1);
  localparam bit ODD_W = (IMG_WIDTH % 2) == 1;
  localparam bit ODD_H = (IMG_HEIGHT % 2) == 1;

  logic [CW-1:0]    col, col_nxt;
  logic [RW-1:0]    row, row_nxt;
  phase_t           phase;
  logic             accept, keep, wr_en, rd_en, load, is_last;
  logic [PIX_W-1:0] pair_reg, res;
  logic [LB_W-1:0]  wr_data, rd_data;
  logic [AW-1:0]    lb_addr;
`ifdef POOL_AVG_EN
  logic [PIX_W+1:0] sum;
`else
  logic [PIX_W-1:0] pair_max;
`endif

  assign pif.ready_out = !pif.valid_out || pif.ready_in;
  assign accept        = pif.valid_in && pif.ready_out;
  assign lb_addr       = AW'(col >> 1);

  always_comb begin
    phase   = phase_t'({row[0], col[0]});
    col_nxt = col;
    row_nxt = row;
    if (accept) begin
      if (col == COL_END) begin
        col_nxt = '0;
        row_nxt = (row == ROW_END) ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
    // The unpaired last column/row of odd-sized frames is consumed but never pooled.
    keep    = !(ODD_W && col == COL_END) && !(ODD_H && row == ROW_END);
    wr_en   = accept && keep && phase == ROW_EVEN_B;
    rd_en   = accept && keep && phase == ROW_ODD_A;
    load    = accept && keep && phase == ROW_ODD_B;
    is_last = (row == ROW_LAST) && (col == COL_LAST);
`ifdef POOL_AVG_EN
    wr_data = {1'b0, pair_reg} + {1'b0, pif.pixel_in};
    sum     = {1'b0, rd_data} + {2'b00, pair_reg} + {2'b00, pif.pixel_in};
    res     = sum[PIX_W+1:2];
`else
    pair_max = (pif.pixel_in > pair_reg) ? pif.pixel_in : pair_reg;
    wr_data  = pair_max;
    res      = (rd_data > pair_max) ? rd_data : pair_max;
`endif
  end

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      pair_reg <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
      if (accept && (phase == ROW_EVEN_A || phase == ROW_ODD_A)) pair_reg <= pif.pixel_in;
    end
  end

  // Load wins over drain, so a same-cycle drain and new result keeps valid_out high.
  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      pif.pixel_out <= '0;
      pif.valid_out <= 1'b0;
      pif.last_out  <= 1'b0;
    end else if (load) begin
      pif.pixel_out <= res;
      pif.valid_out <= 1'b1;
      pif.last_out  <= is_last;
    end else if (pif.valid_out && pif.ready_in) begin
      pif.valid_out <= 1'b0;
      pif.last_out  <= 1'b0;
    end
  end

  pool_line_buf #(.DEPTH(DEPTH), .AW(AW)) u_lb (
    .clk     (clk_200mhz),
    .wr_en   (wr_en),
    .wr_addr (lb_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (lb_addr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_edge_max_pool.sv
// Directed bench for edge_max_pool: three sizes (4x2, 62x62, 5x3) share clock and reset,
// expected tiles are queued from a reference image and checked as outputs transfer.
module tb_edge_max_pool;
  import pool_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PIX_W-1:0] pin [3];
  logic [PIX_W-1:0] pout [3];
  logic vin [3], rin [3], vout [3], lout [3], rout [3];

  int n_vec = 0, n_err = 0;
  int beats [3];
  logic [PIX_W:0] q0 [$], q1 [$], q2 [$];
  int img [64][64];

  edge_max_pool_if if0 ();
  edge_max_pool_if if1 ();
  edge_max_pool_if if2 ();

  assign if0.pixel_in = pin[0]; assign if0.valid_in = vin[0]; assign if0.ready_in = rin[0];
  assign if1.pixel_in = pin[1]; assign if1.valid_in = vin[1]; assign if1.ready_in = rin[1];
  assign if2.pixel_in = pin[2]; assign if2.valid_in = vin[2]; assign if2.ready_in = rin[2];
  assign pout[0] = if0.pixel_out; assign vout[0] = if0.valid_out;
  assign lout[0] = if0.last_out;  assign rout[0] = if0.ready_out;
  assign pout[1] = if1.pixel_out; assign vout[1] = if1.valid_out;
  assign lout[1] = if1.last_out;  assign rout[1] = if1.ready_out;
  assign pout[2] = if2.pixel_out; assign vout[2] = if2.valid_out;
  assign lout[2] = if2.last_out;  assign rout[2] = if2.ready_out;

  edge_max_pool #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) u4 (.clk_200mhz(clk), .reset_n(rst_n), .pif(if0));
  edge_max_pool u62 (.clk_200mhz(clk), .reset_n(rst_n), .pif(if1));
  edge_max_pool #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) u5 (.clk_200mhz(clk), .reset_n(rst_n), .pif(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qsz(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int s, input logic [PIX_W:0] v);
    case (s)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop(input int s, output logic [PIX_W:0] v);
    case (s)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  function automatic logic [PIX_W-1:0] ref_tile(input int tr, input int tc);
    int a, b, c, d, m;
    a = img[2*tr][2*tc];   b = img[2*tr][2*tc+1];
    c = img[2*tr+1][2*tc]; d = img[2*tr+1][2*tc+1];
`ifdef POOL_AVG_EN
    m = (a + b + c + d) >> 2;
`else
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
`endif
    return PIX_W'(m);
  endfunction

  // Transfer happens on the next rising edge whenever valid_out && ready_in at the falling edge.
  task automatic mon(input int s);
    logic [PIX_W:0] e;
    if (vout[s] && rin[s]) begin
      beats[s]++;
      chk($sformatf("out%0d_expected", s), qsz(s) > 0, 1);
      if (qsz(s) > 0) begin
        pop(s, e);
        chk($sformatf("pix%0d", s), pout[s], e[PIX_W-1:0]);
        chk($sformatf("last%0d", s), lout[s], e[PIX_W]);
      end
    end
  endtask

  always @(negedge clk) if (rst_n) for (int s = 0; s < 3; s++) mon(s);

  task automatic send(input int s, input int p);
    int n = 0;
    pin[s] = PIX_W'(p);
    vin[s] = 1'b1;
    @(negedge clk);
    while (!rout[s] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rout[s]) chk($sformatf("accept_timeout%0d", s), rout[s], 1);
    @(posedge clk);
    #1 vin[s] = 1'b0;
  endtask

  task automatic push_frame(input int s, input int w, input int h);
    for (int tr = 0; tr < h / 2; tr++)
      for (int tc = 0; tc < w / 2; tc++)
        push(s, {(tr == h / 2 - 1) && (tc == w / 2 - 1), ref_tile(tr, tc)});
  endtask

  task automatic drive(input int s, input int w, input int from, input int upto);
    for (int i = from; i < upto; i++) send(s, img[i / w][i % w]);
  endtask

  task automatic wait_drain(input int s);
    int n = 0;
    while (qsz(s) != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1 chk($sformatf("drain%0d", s), qsz(s), 0);
  endtask

  task automatic set_tile_img(input int a0, a1, a2, a3, b0, b1, b2, b3);
    img[0][0] = a0; img[0][1] = a1; img[0][2] = a2; img[0][3] = a3;
    img[1][0] = b0; img[1][1] = b1; img[1][2] = b2; img[1][3] = b3;
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      pin[s] = '0; vin[s] = 1'b0; rin[s] = 1'b1; beats[s] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_ready%0d", s), rout[s], 1);
      chk($sformatf("rst_valid%0d", s), vout[s], 0);
      chk($sformatf("rst_last%0d", s), lout[s], 0);
      chk($sformatf("rst_pix%0d", s), pout[s], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x2 basic frame: tiles give 9 then 8 in max mode, last on the second.
    set_tile_img(1, 9, 3, 2, 4, 5, 7, 8);
    push_frame(0, 4, 2);
    drive(0, 4, 0, 8);
    wait_drain(0);
    chk("t1_beats", beats[0], 2);

    // Backpressure: hold the first result, then release mid-frame.
    push_frame(0, 4, 2);
    rin[0] = 1'b0;
    drive(0, 4, 0, 6);
    chk("bp_valid", vout[0], 1);
    chk("bp_pix", pout[0], ref_tile(0, 0));
    chk("bp_ready", rout[0], 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_pix", pout[0], ref_tile(0, 0));
    chk("bp_hold_valid", vout[0], 1);
    chk("bp_hold_ready", rout[0], 0);
    fork
      drive(0, 4, 6, 8);
      begin
        repeat (2) @(posedge clk);
        #1 rin[0] = 1'b1;
      end
    join
    wait_drain(0);
    chk("bp_beats", beats[0], 4);

    // Averaging/overflow tiles: {4,8,12,16} and all 4095.
    set_tile_img(4, 8, 4095, 4095, 12, 16, 4095, 4095);
    push_frame(0, 4, 2);
    drive(0, 4, 0, 8);
    wait_drain(0);

    // Odd 5x3: column 4 and row 2 carry 4095 so any leak into a tile shows up.
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 5; c++)
          img[r][c] = (r == 2 || c == 4) ? 4095 : int'($urandom_range(0, 4000));
      push_frame(2, 5, 3);
      drive(2, 5, 0, 15);
      wait_drain(2);
    end
    chk("odd_beats", beats[2], 4);

    // Reset 70 pixels into a 62-wide ramp frame while a result is held.
    for (int r = 0; r < 62; r++)
      for (int c = 0; c < 62; c++)
        img[r][c] = r * 62 + c;
    for (int tc = 0; tc < 3; tc++) push(1, {1'b0, ref_tile(0, tc)});
    drive(1, 62, 0, 69);
    rin[1] = 1'b0;
    drive(1, 62, 69, 70);
    chk("mid_q_empty", qsz(1), 0);
    chk("mid_valid", vout[1], 1);
    chk("mid_pix", pout[1], 69);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", vout[1], 0);
    chk("arst_ready", rout[1], 1);
    chk("arst_pix", pout[1], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rin[1] = 1'b1;
    beats[1] = 0;

    // Full default-size ramp frame.
    push_frame(1, 62, 62);
    drive(1, 62, 0, 62 * 62);
    wait_drain(1);
    chk("full_beats", beats[1], 961);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
